// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port RAM between the CPU control path (port 0) and a
// DMA/debug requester (port 1). One memory op is in flight at a time. The
// owning port gets its read data plus a one-cycle ack.
//
// Command encoding (shared with the CPU mem_cmd bus):
//   2'b10 read, 2'b01 write, 2'b00 / 2'b11 none
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   p0_cmd     in   port 0 (CPU) command
//   p0_addr    in   port 0 address
//   p0_wdata   in   port 0 write data
//   p0_ack     out  port 0 op complete, one-cycle pulse
//   p1_cmd     in   port 1 (DMA) command
//   p1_addr    in   port 1 address
//   p1_wdata   in   port 1 write data
//   p1_ack     out  port 1 op complete, one-cycle pulse
//   rdata      out  read data for the acked port, valid while its ack is high
//   mem_cmd    out  RAM command
//   mem_addr   out  RAM address
//   mem_wdata  out  RAM write data
//   mem_rdata  in   RAM read data, valid one cycle after a read command
//   busy       out  high while an op is being issued or completed
//
// Build option
//   MEM_ARB_CPU_PRIO_EN : when defined, port 0 wins every tie (fixed
//   priority, port 1 can be starved by a continuously requesting CPU).
//   When undefined (default), ties are broken round robin.
//
// Timing: a request sampled at edge N is issued on the RAM in cycle N+1, and
// its ack is high in cycle N+3. Back-to-back ops therefore run every 3 cycles.

module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        p0_cmd,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  input  logic [1:0]        p1_cmd,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  logic [1:0]        state_reg;
  logic              owner_reg;
  logic              op_read_reg;
  logic [1:0]        mem_cmd_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        ack_reg;
`ifndef MEM_ARB_CPU_PRIO_EN
  logic              last_grant_reg;
`endif

  logic [1:0] port_cmd [2];
  logic [1:0] req;
  logic       grant_valid;
  logic       grant_sel;
  logic [1:0] grant_cmd;

  assign port_cmd[0] = p0_cmd;
  assign port_cmd[1] = p1_cmd;

  // A port whose ack is high this cycle is still allowed to present its old
  // command; masking it here keeps that stale command from being re-granted.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req[gi] = ((port_cmd[gi] == CMD_READ) || (port_cmd[gi] == CMD_WRITE))
                       && !ack_reg[gi];
    end
  endgenerate

  assign grant_valid = |req;

`ifdef MEM_ARB_CPU_PRIO_EN
  // Port 0 wins whenever it asks.
  assign grant_sel = !req[0];
`else
  // On a tie, hand the RAM to the port that did not have it last.
  assign grant_sel = (req[0] && req[1]) ? !last_grant_reg : req[1];
`endif

  assign grant_cmd = grant_sel ? p1_cmd : p0_cmd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      owner_reg      <= 1'b0;
      op_read_reg    <= 1'b0;
      mem_cmd_reg    <= CMD_NONE;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      rdata_reg      <= '0;
      ack_reg        <= 2'b00;
`ifndef MEM_ARB_CPU_PRIO_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      ack_reg <= 2'b00;
      case (state_reg)
        S_IDLE: begin
          if (grant_valid) begin
            owner_reg     <= grant_sel;
            op_read_reg   <= (grant_cmd == CMD_READ);
            mem_cmd_reg   <= grant_cmd;
            mem_addr_reg  <= grant_sel ? p1_addr : p0_addr;
            mem_wdata_reg <= grant_sel ? p1_wdata : p0_wdata;
`ifndef MEM_ARB_CPU_PRIO_EN
            last_grant_reg <= grant_sel;
`endif
            state_reg     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Command is on the RAM for exactly this one cycle.
          mem_cmd_reg <= CMD_NONE;
          state_reg   <= S_RESP;
        end
        S_RESP: begin
          if (op_read_reg) begin
            rdata_reg <= mem_rdata;
          end
          ack_reg   <= owner_reg ? 2'b10 : 2'b01;
          state_reg <= S_IDLE;
        end
        default: begin
          mem_cmd_reg <= CMD_NONE;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_cmd   = mem_cmd_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rdata     = rdata_reg;
  assign p0_ack    = ack_reg[0];
  assign p1_ack    = ack_reg[1];
  assign busy      = (state_reg == S_ISSUE) || (state_reg == S_RESP);

endmodule
